// File: rtl/cdr_pkg.sv
// Shared CDR definitions: phase-bus geometry, bang-bang vote encoding and
// the one-hot to index helper used by the phase encoders.
package cdr_pkg;

  localparam int NUM_PHASES  = 16;
  localparam int PHASE_IDX_W = 4;
  localparam int HALF_UI     = 8;

  typedef enum logic [1:0] {
    VOTE_NONE = 2'd0,
    VOTE_UP   = 2'd1,
    VOTE_DN   = 2'd2
  } vote_e;

  // OR of the indices of all set bits; only meaningful for a one-hot input
  function automatic logic [PHASE_IDX_W-1:0] onehot16_to_idx(
    input logic [NUM_PHASES-1:0] onehot
  );
    logic [PHASE_IDX_W-1:0] idx;
    idx = 4'd0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      idx = idx | (onehot[k] ? PHASE_IDX_W'(k) : 4'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_enc_16.sv
// Combinational 16-way one-hot encoder: phase index plus an exactly-one-bit
// valid flag. Shared by several CDR blocks.
module onehot_enc_16
  import cdr_pkg::*;
(
  input  logic [NUM_PHASES-1:0]  onehot_i,
  output logic [PHASE_IDX_W-1:0] idx_o,
  output logic                   valid_o
);

  // Index and exactly-one-bit check
  always_comb begin
    idx_o   = onehot16_to_idx(onehot_i);
    valid_o = (onehot_i != 16'h0000) &&
              ((onehot_i & (onehot_i - 16'h0001)) == 16'h0000);
  end

endmodule

// File: rtl/phase_selector_16.sv
// Bang-bang CDR phase selector: votes on data-edge position, steers the
// sampling phase to the eye centre. Option macro: PHASE_SEL_GLITCH_FILTER_EN.
module phase_selector_16
  import cdr_pkg::*;
#(
  parameter int FILT_TH  = 4,
  parameter int FILT_W   = 5,
  parameter int LOCK_CNT = 32,
  parameter int INIT_SEL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PHASES-1:0]  phase_in,
  input  logic                   data_in,
  output logic                   data_out,
  output logic                   data_valid,
  output logic [PHASE_IDX_W-1:0] sel_phase,
  output logic                   lock,
  output logic                   phase_err
);

  localparam int                       LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam logic [LOCK_W-1:0]        LOCK_MAX = LOCK_W'(LOCK_CNT);
  localparam logic signed [FILT_W-1:0] TH_POS   = FILT_W'(FILT_TH);
  localparam logic signed [FILT_W-1:0] TH_NEG   = -TH_POS;
  localparam logic [PHASE_IDX_W-1:0]   SEL_RST  = PHASE_IDX_W'(INIT_SEL);
  localparam logic [PHASE_IDX_W-1:0]   HALF_P   = PHASE_IDX_W'(HALF_UI);

  logic                   data_s;
  logic [NUM_PHASES-1:0]  enc_in_s;
  logic                   err_s;
  logic [PHASE_IDX_W-1:0] idx_s;
  logic                   valid_s;

  onehot_enc_16 u_enc (
    .onehot_i (enc_in_s),
    .idx_o    (idx_s),
    .valid_o  (valid_s)
  );

`ifdef PHASE_SEL_GLITCH_FILTER_EN
  logic [2:0]            dsh_q;
  logic [NUM_PHASES-1:0] ph_d1_q;
  logic [NUM_PHASES-1:0] ph_d2_q;

  // Data majority taps and matching two-stage phase delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dsh_q   <= 3'b000;
      ph_d1_q <= 16'h0000;
      ph_d2_q <= 16'h0000;
    end else begin
      dsh_q   <= {dsh_q[1:0], data_in};
      ph_d1_q <= phase_in;
      ph_d2_q <= ph_d1_q;
    end
  end

  // Filtered data; illegal phase is flagged on the raw bus, not the delayed one
  always_comb begin
    data_s   = (dsh_q[0] & dsh_q[1]) | (dsh_q[0] & dsh_q[2]) | (dsh_q[1] & dsh_q[2]);
    enc_in_s = ph_d2_q;
    err_s    = !$onehot(phase_in);
  end
`else
  // Raw data path
  always_comb begin
    data_s   = data_in;
    enc_in_s = phase_in;
    err_s    = !valid_s;
  end
`endif

  logic                   data_q;
  vote_e                  vote_q, vote_d;
  logic signed [FILT_W-1:0] cnt_q, cnt_d;
  logic [PHASE_IDX_W-1:0] sel_q, sel_d;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                   lock_q, lock_d;
  logic                   dout_q, dout_d;
  logic                   dv_q, dv_d;
  logic                   err_q, err_d;
  logic                   edge_s;
  logic                   sample_s;
  logic                   adj_s;
  logic [PHASE_IDX_W-1:0] diff_s;

  // Vote, loop filter, sampling and lock next-state
  always_comb begin
    edge_s   = data_s ^ data_q;
    sample_s = valid_s && (idx_s == sel_q);
    diff_s   = idx_s - sel_q - HALF_P;

    if (valid_s && edge_s) begin
      if (diff_s == 4'd0 || diff_s == HALF_P) begin
        vote_d = VOTE_NONE;
      end else if (diff_s < HALF_P) begin
        vote_d = VOTE_UP;
      end else begin
        vote_d = VOTE_DN;
      end
    end else begin
      vote_d = VOTE_NONE;
    end

    cnt_d = cnt_q;
    sel_d = sel_q;
    adj_s = 1'b0;
    case (vote_q)
      VOTE_UP: begin
        if (cnt_q + FILT_W'(1) == TH_POS) begin
          sel_d = sel_q + 4'd1;
          cnt_d = '0;
          adj_s = 1'b1;
        end else begin
          cnt_d = cnt_q + FILT_W'(1);
        end
      end
      VOTE_DN: begin
        if (cnt_q - FILT_W'(1) == TH_NEG) begin
          sel_d = sel_q - 4'd1;
          cnt_d = '0;
          adj_s = 1'b1;
        end else begin
          cnt_d = cnt_q - FILT_W'(1);
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    // An adjustment restarts the lock count even if a sample lands this cycle
    if (adj_s) begin
      lock_cnt_d = '0;
    end else if (sample_s && (lock_cnt_q != LOCK_MAX)) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
    lock_d = (lock_cnt_d == LOCK_MAX);

    dout_d = sample_s ? data_s : dout_q;
    dv_d   = sample_s;
    err_d  = err_q | err_s;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= 1'b0;
      vote_q     <= VOTE_NONE;
      cnt_q      <= '0;
      sel_q      <= SEL_RST;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      dout_q     <= 1'b0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_q     <= data_s;
      vote_q     <= vote_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign sel_phase  = sel_q;
  assign lock       = lock_q;
  assign phase_err  = err_q;

endmodule

// File: tb/tb_phase_selector_16.sv
// Directed table-driven bench for phase_selector_16 with a free-running
// one-hot phase bus and one data edge per 16-clk unit interval.
module tb_phase_selector_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] phase_in;
  logic        data_in;
  logic        data_out;
  logic        data_valid;
  logic [3:0]  sel_phase;
  logic        lock;
  logic        phase_err;

  always #5 clk = ~clk;

  phase_selector_16 dut (
    .clk        (clk),
    .rst        (rst),
    .phase_in   (phase_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sel_phase  (sel_phase),
    .lock       (lock),
    .phase_err  (phase_err)
  );

  typedef struct {
    logic       do_rst;
    int         e_idx;
    int         n_ui;
    logic [3:0] exp_sel;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[15];

  int         checks = 0;
  int         failures = 0;
  logic [3:0] ph = 4'd0;
  logic       cur_d = 1'b0;
  int         dv_cnt = 0;
  logic       alt_en = 1'b0;
  logic       have_prev = 1'b0;
  logic       prev_dout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk: drive phase/data, wait past the edge, record any sample strobe
  task automatic tick(input logic d, input logic use_ovr, input logic [15:0] ovr);
    logic exp_b;
    phase_in = use_ovr ? ovr : (16'h0001 << ph);
    data_in  = d;
    @(posedge clk);
    #1;
    ph = ph + 4'd1;
    if (data_valid) begin
      dv_cnt++;
      if (alt_en && have_prev) begin
        exp_b = ~prev_dout;
        chk("data_alt", {31'd0, data_out}, {31'd0, exp_b});
      end
      prev_dout = data_out;
      have_prev = 1'b1;
    end
  endtask

  // n unit intervals starting at phase 0, data toggling at phase e
  task automatic run_uis(input int e, input int n);
    dv_cnt    = 0;
    have_prev = 1'b0;
    alt_en    = (e == 8);
    for (int u = 0; u < n; u++) begin
      for (int c = 0; c < 16; c++) begin
        if (ph == 4'(e)) cur_d = ~cur_d;
        tick(cur_d, 1'b0, 16'h0000);
      end
    end
  endtask

  // Async reset with the bus running, release, then first sample at phase 0
  task automatic do_reset();
    alt_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_async_sel",  {28'd0, sel_phase}, 32'd0);
    chk("rst_async_lock", {31'd0, lock}, 32'd0);
    chk("rst_async_dv",   {31'd0, data_valid}, 32'd0);
    chk("rst_async_dout", {31'd0, data_out}, 32'd0);
    chk("rst_async_err",  {31'd0, phase_err}, 32'd0);
    tick(cur_d, 1'b0, 16'h0000);
    tick(cur_d, 1'b0, 16'h0000);
    chk("rst_hold_sel", {28'd0, sel_phase}, 32'd0);
    chk("rst_hold_dv",  {31'd0, data_valid}, 32'd0);
    ph    = 4'd0;
    cur_d = 1'b1;
    rst   = 1'b1;
    tick(cur_d, 1'b0, 16'h0000);
    chk("first_dv",   {31'd0, data_valid}, 32'd1);
    chk("first_dout", {31'd0, data_out}, 32'd1);
    tick(cur_d, 1'b0, 16'h0000);
    chk("first_dv_pulse", {31'd0, data_valid}, 32'd0);
    for (int c = 2; c < 16; c++) tick(cur_d, 1'b0, 16'h0000);
  endtask

  initial begin
    rst      = 1'b0;
    phase_in = 16'h0001;
    data_in  = 1'b0;

    vecs[0]  = '{1'b1, 8, 30, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 8, 1, 4'd0, 1'b1};
    vecs[2]  = '{1'b0, 8, 5, 4'd0, 1'b1};
    vecs[3]  = '{1'b0, 11, 3, 4'd0, 1'b1};
    vecs[4]  = '{1'b0, 11, 1, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 11, 8, 4'd3, 1'b0};
    vecs[6]  = '{1'b0, 11, 31, 4'd3, 1'b0};
    vecs[7]  = '{1'b0, 11, 1, 4'd3, 1'b1};
    vecs[8]  = '{1'b1, 8, 30, 4'd0, 1'b0};
    vecs[9]  = '{1'b0, 8, 1, 4'd0, 1'b1};
    vecs[10] = '{1'b1, 5, 3, 4'd0, 1'b0};
    vecs[11] = '{1'b0, 5, 1, 4'd15, 1'b0};
    vecs[12] = '{1'b0, 5, 8, 4'd13, 1'b0};
    vecs[13] = '{1'b0, 5, 30, 4'd13, 1'b0};
    vecs[14] = '{1'b0, 5, 1, 4'd13, 1'b1};

    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_rst) do_reset();
      run_uis(vecs[i].e_idx, vecs[i].n_ui);
      chk($sformatf("row%0d_sel", i),  {28'd0, sel_phase}, {28'd0, vecs[i].exp_sel});
      chk($sformatf("row%0d_lock", i), {31'd0, lock}, {31'd0, vecs[i].exp_lock});
      chk($sformatf("row%0d_err", i),  {31'd0, phase_err}, 32'd0);
      if (vecs[i].e_idx == 8) begin
        chk($sformatf("row%0d_nsamp", i), dv_cnt, vecs[i].n_ui);
      end
    end

    // Two-hot bus in the sampling slot (phase 13): no sample, sticky error
    dv_cnt = 0;
    alt_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (ph == 4'd5) cur_d = ~cur_d;
      tick(cur_d, (ph == 4'd13), 16'h2001);
    end
    chk("bad_nsamp", dv_cnt, 0);
    chk("bad_err",   {31'd0, phase_err}, 32'd1);
    chk("bad_sel",   {28'd0, sel_phase}, 32'd13);
    chk("bad_lock",  {31'd0, lock}, 32'd1);

    run_uis(5, 1);
    chk("err_sticky",   {31'd0, phase_err}, 32'd1);
    chk("after_nsamp",  dv_cnt, 1);

    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
